// File: rtl/output_switch_guarded_pkg.sv
// output_switch_guarded_pkg: shared constants, FSM state encoding and parameter legality check
// for the guarded N-way output switch and its select synchroniser.
package output_switch_guarded_pkg;

    localparam int CNT_W = 8;

    localparam logic [7:0] DEF_SAFE_VAL = 8'hFF;

    localparam logic [0:0] ST_ACTIVE = 1'b0;
    localparam logic [0:0] ST_GUARD  = 1'b1;

    function automatic bit params_ok(
        input int num_src,
        input int sel_w,
        input int guard_cycles,
        input int reset_src,
        input int sync_stages
    );
        return num_src >= 2 && num_src <= 16 && (1 << sel_w) >= num_src &&
               guard_cycles >= 1 && guard_cycles <= 255 &&
               reset_src >= 0 && reset_src < num_src && sync_stages >= 2;
    endfunction

endpackage

// File: rtl/output_switch_guarded_if.sv
// output_switch_guarded_if: source-side and pin-side signals of the guarded output switch.
//   ctr_io       requested source index (asynchronous to clk)
//   src_data     flattened source buses, source k at [k*WIDTH +: WIDTH]
//   output_pin   registered pin drive
//   active_src   index currently routed
//   switching    high while the guard interval runs
//   switch_done  one-cycle pulse when active_src changes
//   sel_err      synchronised select is out of range
//   switch_count completed switches, wraps mod 2^16
// master: the side that supplies requests and data; slave: the switch itself.
interface output_switch_guarded_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = 1
);
    logic [SEL_W-1:0]         ctr_io;
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [WIDTH-1:0]         output_pin;
    logic [SEL_W-1:0]         active_src;
    logic                     switching;
    logic                     switch_done;
    logic                     sel_err;
    logic [15:0]              switch_count;

    modport master (
        output ctr_io, src_data,
        input  output_pin, active_src, switching, switch_done, sel_err, switch_count
    );

    modport slave (
        input  ctr_io, src_data,
        output output_pin, active_src, switching, switch_done, sel_err, switch_count
    );
endinterface

// File: rtl/output_switch_guarded_sync_bus.sv
// sync_bus: STAGES-deep flop chain bringing a W-bit asynchronous bus into the clk domain.
//   clk  system clock
//   rst  asynchronous active-high reset, every stage loads RST_VAL
//   d    asynchronous input bus
//   q    synchronised bus, d delayed by STAGES edges
module sync_bus #(
    parameter int             W       = 1,
    parameter int             STAGES  = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [STAGES-1:0][W-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ff <= {STAGES{RST_VAL}};
        else
            ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/output_switch_guarded.sv
// output_switch_guarded: registered N-way pin multiplexer that hands the board pins between
// NUM_SRC cores, driving SAFE_VAL for GUARD_CYCLES cycles around every handover.
//   clk  system clock, all logic on posedge
//   rst  asynchronous active-high reset
//   bus  slave side of output_switch_guarded_if (requests, source data, pins, status)
module output_switch_guarded
    import output_switch_guarded_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               NUM_SRC      = 2,
    parameter int               SEL_W        = 1,
    parameter logic [WIDTH-1:0] SAFE_VAL     = WIDTH'(DEF_SAFE_VAL),
    parameter int               GUARD_CYCLES = 4,
    parameter int               SYNC_STAGES  = 2,
    parameter int               RESET_SRC    = 0
) (
    input logic                   clk,
    input logic                   rst,
    output_switch_guarded_if.slave bus
);
    if (!params_ok(NUM_SRC, SEL_W, GUARD_CYCLES, RESET_SRC, SYNC_STAGES)) begin : g_bad_params
        $error("output_switch_guarded: illegal parameter combination");
    end

    logic [SEL_W-1:0] sel_s;
    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             settle;
    logic             sel_valid;
    logic             start;
    logic             last;
    logic [SEL_W-1:0] target;
    logic [WIDTH-1:0] cur_data;

    sync_bus #(
        .W       (SEL_W),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (SEL_W'(RESET_SRC))
    ) u_sel_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.ctr_io),
        .q   (sel_s)
    );

    assign sel_valid = 32'(sel_s) < NUM_SRC;
    assign target    = sel_valid ? sel_s : bus.active_src;
    assign cur_data  = bus.src_data[32'(bus.active_src) * WIDTH +: WIDTH];

    // The first ACTIVE cycle after a guard always shows the new source, so two
    // back-to-back handovers never merge into one long SAFE run.
    assign start = sel_valid && sel_s != bus.active_src && !settle;

    // SAFE covers the entry edge plus GUARD_CYCLES-1 guard edges; the exit is the
    // edge that takes the counter down to zero.
    assign last = cnt <= CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_ACTIVE;
            cnt              <= '0;
            settle           <= 1'b0;
            bus.output_pin   <= SAFE_VAL;
            bus.active_src   <= SEL_W'(RESET_SRC);
            bus.switching    <= 1'b0;
            bus.switch_done  <= 1'b0;
            bus.sel_err      <= 1'b0;
            bus.switch_count <= '0;
        end else begin
            bus.sel_err     <= !sel_valid;
            bus.switch_done <= 1'b0;
            settle          <= 1'b0;
            if (state == ST_ACTIVE) begin
                if (start) begin
                    state          <= ST_GUARD;
                    cnt            <= CNT_W'(GUARD_CYCLES - 1);
                    bus.output_pin <= SAFE_VAL;
                    bus.switching  <= 1'b1;
                end else begin
                    bus.output_pin <= cur_data;
                end
            end else begin
                bus.output_pin <= SAFE_VAL;
                cnt            <= cnt - CNT_W'(1);
                if (last) begin
                    state          <= ST_ACTIVE;
                    bus.switching  <= 1'b0;
                    bus.active_src <= target;
                    settle         <= 1'b1;
                    if (target != bus.active_src) begin
                        bus.switch_done  <= 1'b1;
                        bus.switch_count <= bus.switch_count + 16'd1;
                    end
                end
            end
        end
    end
endmodule
